fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
// The fetch unit connects through the master modport.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_instr,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_instr,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: a PC, a one-deep request tracker for a synchronous
// instruction memory and a two-entry in-order buffer feeding decode.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input logic         clk,
    input logic         reset,
    fetch_unit_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_addr;
    logic            inflight;
    logic [1:0]      count;
    logic [XLEN-1:0] ent0_pc, ent1_pc;
    logic [31:0]     ent0_instr, ent1_instr;

    logic [XLEN-1:0] aligned_target;
    logic [XLEN-1:0] fetch_addr;
    logic            issue;
    logic            pop;
    logic            push;
    logic [1:0]      remaining;

    // Masking rather than slicing keeps every redirect_pc bit in use.
    assign aligned_target = bus.redirect_pc & ~(XLEN'(3));
    assign fetch_addr     = bus.redirect_valid ? aligned_target : pc;

    // A redirect flushes both the buffer and whatever response is returning.
    assign pop       = (count != 2'd0) && bus.id_ready && !bus.redirect_valid;
    assign push      = inflight && !bus.redirect_valid;
    assign remaining = count - {1'b0, pop};

    assign issue = !reset &&
                   (((3'(count) + 3'(inflight)) < 3'd2) ||
                    ((count != 2'd0) && bus.id_ready) ||
                    bus.redirect_valid);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = reset ? RESET_PC : fetch_addr;
    assign bus.id_valid  = (count != 2'd0);
    assign bus.id_pc     = ent0_pc;
    assign bus.id_instr  = ent0_instr;

    // Entry 0 is always the head; it keeps its contents when the buffer
    // drains so decode sees the last instruction held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= RESET_PC;
            count         <= 2'd0;
            ent0_pc       <= RESET_PC;
            ent0_instr    <= NOP;
            ent1_pc       <= RESET_PC;
            ent1_instr    <= NOP;
        end else begin
            inflight      <= issue;
            inflight_addr <= fetch_addr;
            if (issue) begin
                pc <= fetch_addr + XLEN'(PC_STEP);
            end

            if (bus.redirect_valid) begin
                count <= 2'd0;
            end else begin
                count <= remaining + {1'b0, push};
            end

            if (pop && (count == 2'd2)) begin
                ent0_pc    <= ent1_pc;
                ent0_instr <= ent1_instr;
            end

            if (push) begin
                if (remaining == 2'd0) begin
                    ent0_pc    <= inflight_addr;
                    ent0_instr <= bus.imem_rdata;
                end else begin
                    ent1_pc    <= inflight_addr;
                    ent1_instr <= bus.imem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic,
// every cycle compared against a queue-based model of the fetch behaviour.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN    (32),
        .RESET_PC(RST_PC),
        .PC_STEP (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc        = RST_PC;
    logic [31:0] m_infl_addr = RST_PC;
    logic [31:0] m_last_pc   = RST_PC;
    logic [31:0] m_last_instr = NOP;
    bit          m_infl      = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance
    // the model, then let the memory answer the request seen this cycle.
    task automatic apply_stimulus(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
        bit          e_req, e_valid, resp_req;
        logic [31:0] e_addr, e_pc, e_instr, resp_addr;

        reset              = rst;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        #1;

        if (rst) begin
            e_req   = 1'b0;
            e_addr  = RST_PC;
            e_valid = 1'b0;
            e_pc    = RST_PC;
            e_instr = NOP;
        end else begin
            e_valid = (mq.size() != 0);
            e_pc    = e_valid ? mq[0].pc    : m_last_pc;
            e_instr = e_valid ? mq[0].instr : m_last_instr;
            e_req   = ((mq.size() + int'(m_infl)) < 2) || (e_valid && rdy) || redir;
            e_addr  = redir ? {rpc[31:2], 2'b00} : m_pc;
        end

        check_output("imem_req",  32'(bus.imem_req), 32'(e_req));
        check_output("imem_addr", bus.imem_addr,     e_addr);
        check_output("id_valid",  32'(bus.id_valid), 32'(e_valid));
        check_output("id_pc",     bus.id_pc,         e_pc);
        check_output("id_instr",  bus.id_instr,      e_instr);

        resp_req  = bus.imem_req;
        resp_addr = bus.imem_addr;

        if (rst) begin
            mq.delete();
            m_infl       = 1'b0;
            m_pc         = RST_PC;
            m_last_pc    = RST_PC;
            m_last_instr = NOP;
        end else begin
            m_last_pc    = e_pc;
            m_last_instr = e_instr;
            if (redir) begin
                mq.delete();
                m_infl      = 1'b1;
                m_infl_addr = e_addr;
                m_pc        = e_addr + 32'd4;
            end else begin
                if (e_valid && rdy) void'(mq.pop_front());
                if (m_infl) mq.push_back(entry_t'{pc: m_infl_addr, instr: mem_word(m_infl_addr)});
                m_infl = e_req;
                if (e_req) begin
                    m_infl_addr = m_pc;
                    m_pc        = m_pc + 32'd4;
                end
            end
        end

        @(posedge clk);
        #1;
        bus.imem_rdata = resp_req ? mem_word(resp_addr) : 32'hDEAD_BEEF;
    endtask

    initial begin
        int r;
        bus.imem_rdata     = 32'hDEAD_BEEF;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        $display("[TB] start, RESET_PC=%h", RST_PC);
        @(posedge clk);
        #1;

        // Reset state, then streaming across the address wrap.
        repeat (2) apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (8) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Decode stall: buffer fills to two and requests stop.
        repeat (5) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect while the buffer is full.
        repeat (3) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        repeat (4) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Misaligned target, then back-to-back redirects.
        apply_stimulus(1'b0, 1'b1, 32'h0000_0203, 1'b1);
        repeat (3) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h0000_0400, 1'b1);
        repeat (4) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset with a full buffer and a request in flight.
        repeat (4) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 99));
            apply_stimulus(r < 2, (r >= 2) && (r < 12), $urandom, $urandom_range(0, 9) < 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
